// File: rtl/pid_pkg.sv
// Shared constants for the PID coefficient scheduler:
// coefficient addresses and sample-timer state encoding.
package pid_pkg;

  localparam int NUM_COEF = 5;

  localparam logic [2:0] B0 = 3'd0;
  localparam logic [2:0] B1 = 3'd1;
  localparam logic [2:0] B2 = 3'd2;
  localparam logic [2:0] A0 = 3'd3;
  localparam logic [2:0] A1 = 3'd4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/pid_sample_timer.sv
// Sample-period down-counter with IDLE/RUN control.
// Raises tick_o for the cycle in which the count reaches zero.
module pid_sample_timer
  import pid_pkg::*;
#(
  parameter int DIV_BITWIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic [DIV_BITWIDTH-1:0] div_i,
  output logic                    tick_o
);

  state_e                  r_state;
  logic [DIV_BITWIDTH-1:0] r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_cnt <= div_i;
          if (enable_i) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (!enable_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= div_i;
          end else if (r_cnt == '0) begin
            r_cnt <= div_i;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tick_o = (r_state == ST_RUN) && (r_cnt == '0);

endmodule

// File: rtl/pid_coeff_sched.sv
// PID coefficient scheduler: sample strobe generation plus a
// byte-writable shadow bank committed atomically between samples.
module pid_coeff_sched
  import pid_pkg::*;
#(
  parameter int REG_BITWIDTH = 32,
  parameter int DIV_BITWIDTH = 16,
  localparam int NLANES = REG_BITWIDTH / 8,
  localparam int LANE_W = (NLANES > 1) ? $clog2(NLANES) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           enable_i,
  input  logic [DIV_BITWIDTH-1:0]        div_i,
  input  logic                           busy_i,
  input  logic                           wr_en_i,
  input  logic [2:0]                     wr_addr_i,
  input  logic [LANE_W-1:0]              wr_byte_i,
  input  logic [7:0]                     wr_data_i,
  input  logic                           commit_i,
  output logic                           clk_en_PID_o,
  output logic signed [REG_BITWIDTH-1:0] b0_reg_o,
  output logic signed [REG_BITWIDTH-1:0] b1_reg_o,
  output logic signed [REG_BITWIDTH-1:0] b2_reg_o,
  output logic signed [REG_BITWIDTH-1:0] a0_reg_o,
  output logic signed [REG_BITWIDTH-1:0] a1_reg_o,
  output logic                           commit_pending_o,
  output logic                           overrun_o
);

  logic                    w_tick;
  logic                    w_apply;
  logic                    r_strobe;
  logic                    r_pending;
  logic                    r_overrun;
  logic [REG_BITWIDTH-1:0] r_shadow     [NUM_COEF];
  logic [REG_BITWIDTH-1:0] w_shadow_nxt [NUM_COEF];
  logic [REG_BITWIDTH-1:0] r_active     [NUM_COEF];

  pid_sample_timer #(
    .DIV_BITWIDTH(DIV_BITWIDTH)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .enable_i(enable_i),
    .div_i   (div_i),
    .tick_o  (w_tick)
  );

  // Same-edge writes are folded in so a commit sees the live shadow.
  always_comb begin
    for (int k = 0; k < NUM_COEF; k++) w_shadow_nxt[k] = r_shadow[k];
    if (wr_en_i && (wr_addr_i <= A1) && (int'(wr_byte_i) < NLANES))
      w_shadow_nxt[wr_addr_i][8*wr_byte_i +: 8] = wr_data_i;
  end

  assign w_apply = r_pending && !busy_i && !r_strobe;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_strobe  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_strobe <= w_tick && !busy_i;
      if (w_tick && busy_i) r_overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pending <= 1'b0;
      for (int k = 0; k < NUM_COEF; k++) begin
        r_shadow[k] <= '0;
        r_active[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_COEF; k++) r_shadow[k] <= w_shadow_nxt[k];
      if (w_apply) begin
        r_pending <= 1'b0;
        for (int k = 0; k < NUM_COEF; k++) r_active[k] <= w_shadow_nxt[k];
      end else if (commit_i) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign clk_en_PID_o     = r_strobe;
  assign commit_pending_o = r_pending;
  assign overrun_o        = r_overrun;
  assign b0_reg_o         = $signed(r_active[B0]);
  assign b1_reg_o         = $signed(r_active[B1]);
  assign b2_reg_o         = $signed(r_active[B2]);
  assign a0_reg_o         = $signed(r_active[A0]);
  assign a1_reg_o         = $signed(r_active[A1]);

endmodule
